adat_tx_frame_encoder: RTL and testbench

ADAT optical-line transmitter: accepts one frame of eight 24-bit samples plus four user bits per handshake and serialises it as a 256-bit ADAT frame in NRZI form. The NRZI run lengths it produces are the edge intervals the receive-side bit decoder measures. The block sits between the audio sample source and the TOSLINK driver pin, and advances one line bit per `i_bit_tick`, which the clock-enable generator issues at 256×fs.

---
 rtl/adat_tx_frame_encoder.sv | 188 ++++++++++++++++++
 tb/tb_adat_tx_frame_encoder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/adat_tx_frame_encoder.sv
// -----------------------------------------------------------------------------
// adat_tx_frame_encoder
//
// ADAT optical-line transmitter. Accepts one frame of eight 24-bit samples plus
// four user bits per valid/ready handshake into a one-deep holding buffer, then
// serialises it as a 256-bit ADAT frame in NRZI form, one line bit per
// i_bit_tick (256 x fs).
//
// Logical frame layout: bits 0-9 = 0, bit 10 = 1, bits 11-14 = U3..U0,
// bit 15 = 1, then channels 0..7, each as six nibbles (MSB nibble first),
// every nibble sent MSB first and followed by a '1' separator. Bit 255 = 1.
//
// Build option:
//   ADAT_TX_REPEAT_ON_UNDERRUN_EN  defined   -> on underrun the previous frame
//                                              is sent again.
//                                  undefined -> on underrun an all-zero
//                                              (silence) frame is sent.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst          asynchronous active-low reset
//   i_bit_tick     one-cycle enable, one line bit per tick
//   i_valid        frame offered on i_samples / i_user
//   o_ready        holding buffer empty
//   i_samples      channel n at [24n+23:24n]
//   i_user         user bits U3..U0
//   o_adat         registered NRZI line output
//   o_frame_start  one-cycle pulse after the bit-0 tick
//   o_underrun     one-cycle pulse after a bit-0 tick with no pending frame
//   o_bit_index    index of the next bit to be sent
// -----------------------------------------------------------------------------
module adat_tx_frame_encoder #(
   parameter int NUM_CH   = 8,
   parameter int SAMPLE_W = 24
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_bit_tick,
   input  logic                         i_valid,
   output logic                         o_ready,
   input  logic [NUM_CH*SAMPLE_W-1:0]   i_samples,
   input  logic [3:0]                   i_user,
   output logic                         o_adat,
   output logic                         o_frame_start,
   output logic                         o_underrun,
   output logic [7:0]                   o_bit_index
);

   localparam int PAY_W = NUM_CH * SAMPLE_W;
   localparam int NIB_N = SAMPLE_W / 4;

   // Expands raw samples and user bits into the 256 logical line bits.
   // Pure wiring: every index is a constant once the loops unroll.
   function automatic logic [255:0] build_frame(input logic [PAY_W-1:0] s,
                                                input logic [3:0]       u);
      logic [255:0] f;
      int           base;
      f       = 256'd0;
      f[10]   = 1'b1;
      f[11]   = u[3];
      f[12]   = u[2];
      f[13]   = u[1];
      f[14]   = u[0];
      f[15]   = 1'b1;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         for (int nib = 0; nib < NIB_N; nib++) begin
            base = 16 + ch * (NIB_N * 5) + nib * 5;
            for (int b = 0; b < 4; b++) begin
               f[base + b] = s[ch * SAMPLE_W + SAMPLE_W - 1 - nib * 4 - b];
            end
            f[base + 4] = 1'b1;
         end
      end
      return f;
   endfunction

   logic [PAY_W-1:0] hold_samples_r;
   logic [3:0]       hold_user_r;
   logic             pending_r;
   logic [PAY_W-1:0] act_samples_r;
   logic [3:0]       act_user_r;
   logic             adat_r;
   logic [7:0]       bit_index_r;
   logic             frame_start_r;
   logic             underrun_r;

   logic             xfer_s;
   logic             load_s;
   logic             pending_nxt_s;
   logic [PAY_W-1:0] act_samples_nxt_s;
   logic [3:0]       act_user_nxt_s;
   logic             adat_nxt_s;
   logic [7:0]       bit_index_nxt_s;
   logic [255:0]     frame_bits_s;

   // Logical bits of the frame currently on the line.
   always_comb begin
      frame_bits_s = build_frame(act_samples_r, act_user_r);
   end

   // Handshake, frame load and line-bit next-state logic.
   always_comb begin
      xfer_s            = i_valid && !pending_r;
      load_s            = i_bit_tick && (bit_index_r == 8'd0);
      pending_nxt_s     = pending_r;
      act_samples_nxt_s = act_samples_r;
      act_user_nxt_s    = act_user_r;
      adat_nxt_s        = adat_r;
      bit_index_nxt_s   = bit_index_r;

      // A transfer only happens while pending is clear, so it never collides
      // with a load that empties the buffer; a load with the buffer empty sees
      // the old (empty) state and the new frame waits for the next frame.
      if (xfer_s) begin
         pending_nxt_s = 1'b1;
      end else if (load_s) begin
         pending_nxt_s = 1'b0;
      end else begin
         pending_nxt_s = pending_r;
      end

      // Bit 0 is constant, so swapping the payload on the bit-0 tick is safe.
      if (load_s) begin
         if (pending_r) begin
            act_samples_nxt_s = hold_samples_r;
            act_user_nxt_s    = hold_user_r;
         end else begin
`ifdef ADAT_TX_REPEAT_ON_UNDERRUN_EN
            act_samples_nxt_s = act_samples_r;
            act_user_nxt_s    = act_user_r;
`else
            act_samples_nxt_s = {PAY_W{1'b0}};
            act_user_nxt_s    = 4'd0;
`endif
         end
      end else begin
         act_samples_nxt_s = act_samples_r;
         act_user_nxt_s    = act_user_r;
      end

      if (i_bit_tick) begin
         adat_nxt_s      = adat_r ^ frame_bits_s[bit_index_r];
         bit_index_nxt_s = bit_index_r + 8'd1;
      end else begin
         adat_nxt_s      = adat_r;
         bit_index_nxt_s = bit_index_r;
      end
   end

   // Holding buffer capture on an accepted transfer.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         hold_samples_r <= {PAY_W{1'b0}};
         hold_user_r    <= 4'd0;
      end else if (xfer_s) begin
         hold_samples_r <= i_samples;
         hold_user_r    <= i_user;
      end
   end

   // Active frame, pending flag, line output, counter and status pulses.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         pending_r     <= 1'b0;
         act_samples_r <= {PAY_W{1'b0}};
         act_user_r    <= 4'd0;
         adat_r        <= 1'b0;
         bit_index_r   <= 8'd0;
         frame_start_r <= 1'b0;
         underrun_r    <= 1'b0;
      end else begin
         pending_r     <= pending_nxt_s;
         act_samples_r <= act_samples_nxt_s;
         act_user_r    <= act_user_nxt_s;
         adat_r        <= adat_nxt_s;
         bit_index_r   <= bit_index_nxt_s;
         frame_start_r <= load_s;
         underrun_r    <= load_s && !pending_r;
      end
   end

   assign o_ready       = !pending_r;
   assign o_adat        = adat_r;
   assign o_bit_index   = bit_index_r;
   assign o_frame_start = frame_start_r;
   assign o_underrun    = underrun_r;

endmodule

// File: tb/tb_adat_tx_frame_encoder.sv
// -----------------------------------------------------------------------------
// tb_adat_tx_frame_encoder
//
// Directed bench for adat_tx_frame_encoder: silence frame, pattern decode,
// handshake backpressure, underrun, simultaneous transfer/load and reset in
// the middle of a frame. Expected line bits are hand-written constants.
// -----------------------------------------------------------------------------
module tb_adat_tx_frame_encoder;

   logic         clk;
   logic         i_rst;
   logic         i_bit_tick;
   logic         i_valid;
   logic         o_ready;
   logic [191:0] i_samples;
   logic [3:0]   i_user;
   logic         o_adat;
   logic         o_frame_start;
   logic         o_underrun;
   logic [7:0]   o_bit_index;

   int passed;
   int total;

   logic [0:255] fb;
   logic [0:255] sil;
   logic         fs0, ur0, rdy0, fs1, ur1;

   adat_tx_frame_encoder dut (
      .i_clk         (clk),
      .i_rst         (i_rst),
      .i_bit_tick    (i_bit_tick),
      .i_valid       (i_valid),
      .o_ready       (o_ready),
      .i_samples     (i_samples),
      .i_user        (i_user),
      .o_adat        (o_adat),
      .o_frame_start (o_frame_start),
      .o_underrun    (o_underrun),
      .o_bit_index   (o_bit_index)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Sends one full frame with back-to-back ticks, starting at bit 0, and
   // demodulates the line by XOR of successive o_adat values.
   task automatic run_frame(input logic drop_valid, output logic [0:255] bits,
                            output logic fs_a, output logic ur_a, output logic rdy_a,
                            output logic fs_b, output logic ur_b);
      logic prev;
      fs_a = 1'b0; ur_a = 1'b0; rdy_a = 1'b0; fs_b = 1'b0; ur_b = 1'b0;
      for (int i = 0; i < 256; i++) begin
         prev       = o_adat;
         i_bit_tick = 1'b1;
         @(negedge clk);
         if (i == 0) begin
            fs_a  = o_frame_start;
            ur_a  = o_underrun;
            rdy_a = o_ready;
            if (drop_valid) i_valid = 1'b0;
         end
         if (i == 1) begin
            fs_b = o_frame_start;
            ur_b = o_underrun;
         end
         bits[i] = o_adat ^ prev;
      end
      i_bit_tick = 1'b0;
   endtask

   initial begin
      passed     = 0;
      total      = 0;
      i_rst      = 1'b0;
      i_bit_tick = 1'b0;
      i_valid    = 1'b0;
      i_samples  = 192'd0;
      i_user     = 4'd0;

      sil = '0;
      sil[10] = 1'b1;
      for (int k = 15; k < 256; k += 5) sil[k] = 1'b1;

      repeat (3) @(negedge clk);
      chk("rst_adat", {255'd0, o_adat}, 256'd0);
      chk("rst_idx", {248'd0, o_bit_index}, 256'd0);
      chk("rst_ready", {255'd0, o_ready}, 256'd1);
      chk("rst_fs", {255'd0, o_frame_start}, 256'd0);
      chk("rst_ur", {255'd0, o_underrun}, 256'd0);
      i_rst = 1'b1;
      @(negedge clk);

      // Silence frame
      i_valid = 1'b1;
      @(negedge clk);
      i_valid = 1'b0;
      chk("sil_ready_low", {255'd0, o_ready}, 256'd0);
      run_frame(1'b0, fb, fs0, ur0, rdy0, fs1, ur1);
      chk("sil_fs", {255'd0, fs0}, 256'd1);
      chk("sil_ur", {255'd0, ur0}, 256'd0);
      chk("sil_ready_back", {255'd0, rdy0}, 256'd1);
      chk("sil_fs_width", {255'd0, fs1}, 256'd0);
      chk("sil_bits", fb, sil);
      chk("sil_toggles", 256'($countones(fb)), 256'd50);
      chk("sil_end_adat", {255'd0, o_adat}, 256'd0);
      chk("sil_end_idx", {248'd0, o_bit_index}, 256'd0);

      // Pattern frame A, then frame B offered immediately (backpressure)
      i_samples        = 192'd0;
      i_samples[23:0]  = 24'hABCDEF;
      i_user           = 4'hA;
      i_valid          = 1'b1;
      @(negedge clk);
      i_samples         = 192'd0;
      i_samples[191:168] = 24'h123456;
      i_user            = 4'h5;
      repeat (3) @(negedge clk);
      chk("bp_ready_low", {255'd0, o_ready}, 256'd0);
      run_frame(1'b0, fb, fs0, ur0, rdy0, fs1, ur1);
      i_valid = 1'b0;
      chk("pat_fs", {255'd0, fs0}, 256'd1);
      chk("pat_ur", {255'd0, ur0}, 256'd0);
      chk("pat_ready_after_load", {255'd0, rdy0}, 256'd1);
      chk("pat_user", {251'd0, fb[11:15]}, {251'd0, 5'b10101});
      chk("pat_ch0", {226'd0, fb[16:45]}, {226'd0, 30'b10101_10111_11001_11011_11101_11111});
      chk("pat_ch7_sep", {226'd0, fb[226:255]}, {226'd0, 30'b00001_00001_00001_00001_00001_00001});
      chk("bp_pending_B", {255'd0, o_ready}, 256'd0);

      // Frame B transmitted
      run_frame(1'b0, fb, fs0, ur0, rdy0, fs1, ur1);
      chk("B_ur", {255'd0, ur0}, 256'd0);
      chk("B_user", {251'd0, fb[11:15]}, {251'd0, 5'b01011});
      chk("B_ch0", {226'd0, fb[16:45]}, {226'd0, 30'b00001_00001_00001_00001_00001_00001});
      chk("B_ch7", {226'd0, fb[226:255]}, {226'd0, 30'b00011_00101_00111_01001_01011_01101});
      chk("B_ready", {255'd0, o_ready}, 256'd1);

      // Underrun
      run_frame(1'b0, fb, fs0, ur0, rdy0, fs1, ur1);
      chk("ur_pulse", {255'd0, ur0}, 256'd1);
      chk("ur_fs", {255'd0, fs0}, 256'd1);
      chk("ur_width", {255'd0, ur1}, 256'd0);
`ifdef ADAT_TX_REPEAT_ON_UNDERRUN_EN
      chk("ur_repeat_user", {251'd0, fb[11:15]}, {251'd0, 5'b01011});
      chk("ur_repeat_ch7", {226'd0, fb[226:255]}, {226'd0, 30'b00011_00101_00111_01001_01011_01101});
`else
      chk("ur_silence", fb, sil);
`endif

      // Simultaneous transfer and bit-0 load with nothing pending
      i_samples       = 192'd0;
      i_samples[23:0] = 24'h000001;
      i_user          = 4'h1;
      i_valid         = 1'b1;
      run_frame(1'b1, fb, fs0, ur0, rdy0, fs1, ur1);
      chk("sim_ur", {255'd0, ur0}, 256'd1);
      chk("sim_ready_low", {255'd0, rdy0}, 256'd0);
`ifdef ADAT_TX_REPEAT_ON_UNDERRUN_EN
      chk("sim_payload", {251'd0, fb[11:15]}, {251'd0, 5'b01011});
`else
      chk("sim_payload", fb, sil);
`endif
      run_frame(1'b0, fb, fs0, ur0, rdy0, fs1, ur1);
      chk("sim_next_ur", {255'd0, ur0}, 256'd0);
      chk("sim_next_user", {251'd0, fb[11:15]}, {251'd0, 5'b00011});
      chk("sim_next_ch0", {226'd0, fb[16:45]}, {226'd0, 30'b00001_00001_00001_00001_00001_00011});

      // Reset in the middle of a frame
      for (int i = 0; i < 137; i++) begin
         i_bit_tick = 1'b1;
         @(negedge clk);
      end
      i_bit_tick = 1'b0;
      i_valid    = 1'b1;
      @(negedge clk);
      i_valid    = 1'b0;
      chk("mid_idx", {248'd0, o_bit_index}, 256'd137);
      chk("mid_ready", {255'd0, o_ready}, 256'd0);
      i_rst = 1'b0;
      #1;
      chk("rst_mid_idx", {248'd0, o_bit_index}, 256'd0);
      chk("rst_mid_adat", {255'd0, o_adat}, 256'd0);
      chk("rst_mid_ready", {255'd0, o_ready}, 256'd1);
      repeat (2) @(negedge clk);
      i_rst = 1'b1;
      @(negedge clk);
      i_bit_tick = 1'b1;
      @(negedge clk);
      i_bit_tick = 1'b0;
      chk("post_rst_fs", {255'd0, o_frame_start}, 256'd1);
      chk("post_rst_idx", {248'd0, o_bit_index}, 256'd1);
      chk("post_rst_ur", {255'd0, o_underrun}, 256'd1);
      chk("post_rst_adat", {255'd0, o_adat}, 256'd0);
      @(negedge clk);
      chk("idle_hold_idx", {248'd0, o_bit_index}, 256'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
